img_conv_engine: RTL and testbench
==================================

# img_conv_engine

Row-sequenced 3x3 filter engine that consumes rows from the dual-image row buffer and writes filtered rows back into its recent-image bank. Reads a source image (original or recent) through the buffer's three row read ports, keeps a sliding 3-row window, applies the selected kernel to all 128 pixels of a row in parallel, and writes each result row back. It sits directly downstream of the row buffer on the read side and upstream of it on the write side, under coprocessor command control.

## Interface
- IMG_W, 128: pixels per row
- IMG_H, 128: rows per image
- PIX_W, 24: bits per pixel, {R,G,B}, B at LSB; pixel p at bits [24p+23:24p]
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse, sampled only in IDLE
- op  in  2  0 copy, 1 blur (1-2-1 Gaussian /16), 2 sharpen, 3 edge (Laplacian)
- src_sel  in  1  source image: 0 original, 1 recent; latched on start
- busy  out  1  high from the cycle after start until the last write
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky illegal-op flag; cleared by the next accepted start
- raddr0/raddr1/raddr2  out  7  row read addresses to the buffer
- re  out  1  buffer read enable
- img_idx  out  1  buffer image select, equals latched src_sel
- rdata0/rdata1/rdata2  in  3072  buffer read rows; valid the cycle after re
- waddr  out  9  write row address; bits [8:7] always 0
- we  out  1  buffer write enable; always targets the recent image
- wdata  out  3072  filtered row

## Operation
- FSM: IDLE, RD, CAP, CALC, WR, FIN.
- IDLE + start: latch op and src_sel, clear err, set row r=0, go to RD.
- RD, first row: raddr0=0, raddr1=0, raddr2=1, re=1. Later rows: raddr2=min(r+1,127), re=1, raddr0/raddr1 held.
- CAP, first row: window {top,mid,bot} <= {rdata0,rdata1,rdata2}. Later rows: window <= {mid,bot,rdata2}.
- CALC: register the kernel result for all pixels into wdata.
- WR: we=1 and waddr=r for one cycle. If r==127, go to FIN. Otherwise r++ and go to RD.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Vertical edges: row -1 replicates row 0, row 128 replicates row 127 through clamped addresses.
- Horizontal edges: pixel -1 replicates pixel 0, pixel 128 replicates pixel 127.
- Per-channel arithmetic: signed 13-bit, result clamped to 0..255.
  - Blur: (4c + 2·orthogonal sum + diagonal sum) >> 4, floor.
  - Sharpen: 5c − N − S − E − W.
  - Edge: 8c − sum of the 8 neighbours.
- In-place safety: rows are always read ahead of the row being written, so src_sel=1 is safe.
- start while not IDLE is ignored.
- Reset mid-operation: the engine returns to IDLE next edge with re=we=0. Rows already written stay written.

## Timing
- Reset values: busy, done, err, re, we, img_idx = 0; raddr*, waddr = 0; wdata = 0.
- Each row takes 4 cycles.
- If start is sampled at edge 0, busy rises after edge 0.
- WR for row r is active during cycle 4r+4.
- done is high in cycle 513; busy is low in that cycle.
- Buffer read latency: 1 cycle.

## Configuration
- IMG_EDGE_EN defined: op 3 performs the Laplacian.
- IMG_EDGE_EN undefined: op 3 is illegal. On start with op 3, err=1, no reads or writes occur, and done pulses in the cycle after start.

## Structure
- Shared package img_coproc_pkg holds:
  - IMG_W, IMG_H, PIX_W, ROW_W=3072
  - op_t enum (OP_COPY, OP_BLUR, OP_SHARP, OP_EDGE)
  - conv_state_t enum
  - clamp8 function
- Sub-module img_kernel_px: combinational, one pixel's 3x3 neighbourhood (9×24 bits) plus op in, 24-bit result out. 128 instances are generated.

## Test plan
- Uniform 0x404040 image, op=blur, src_sel=0 -> all 128 written rows are 0x404040 per pixel, done at cycle 513, exactly 128 we pulses with waddr 0..127.
- Single G=0xFF pixel at (64,64), rest 0, op=blur -> written G values: 0x3F at the centre, 0x1F at the 4 orthogonal neighbours, 0x0F at the 4 diagonals, 0 elsewhere.
- Same image, op=sharpen -> centre G=0xFF (1275 clamped), orthogonal neighbours 0 (−255 clamped).
- op=copy with src_sel=1 on the recent image, run twice back-to-back -> image unchanged; start pulsed at cycle 100 while busy is ignored.
- Assert rst during WR of row 10 -> next cycle re=we=busy=0; a fresh start completes normally in 512 cycles.
- op=3 with IMG_EDGE_EN undefined -> err=1, done in the next cycle, no re/we. With IMG_EDGE_EN defined, a uniform image gives all-zero output.

Source files
------------

// File: rtl/img_coproc_pkg.sv
// img_coproc_pkg: shared image geometry, op and state encodings, and the
// per-channel saturation helper used by the convolution engine.
// Optional feature macro: IMG_EDGE_EN (enables the Laplacian edge op).
package img_coproc_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int PIX_W = 24;
  localparam int ROW_W = IMG_W * PIX_W;

  typedef enum logic [1:0] {
    OP_COPY  = 2'd0,
    OP_BLUR  = 2'd1,
    OP_SHARP = 2'd2,
    OP_EDGE  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_CALC,
    S_WR,
    S_FIN
  } conv_state_t;

  // Saturate a signed 13-bit channel result into the 0..255 pixel range.
  function automatic logic [7:0] clamp8(input logic signed [12:0] v);
    if (v < 13'sd0) return 8'd0;
    else if (v > 13'sd255) return 8'hFF;
    else return v[7:0];
  endfunction

endpackage

// File: rtl/img_kernel_px.sv
// img_kernel_px: combinational 3x3 filter for one pixel. The neighbourhood
// arrives as nine 24-bit pixels, slot k = row*3 + col with the top-left
// neighbour at the LSB; each of R, G, B is filtered independently.
// Optional feature macro: IMG_EDGE_EN (Laplacian for op 3; otherwise op 3
// falls through to a pass-through and is rejected upstream).
module img_kernel_px
  import img_coproc_pkg::*;
(
  input  logic [9*PIX_W-1:0] i_win,
  input  logic [1:0]         i_op,
  output logic [PIX_W-1:0]   o_pix
);

  logic [71:0] w_chan [3];

  // One channel of the 3x3 kernel; n holds nine 8-bit taps, slot k at [8k+:8].
  function automatic logic [7:0] calcChan(input logic [1:0] op, input logic [71:0] n);
    logic signed [12:0] p [9];
    logic signed [12:0] orth;
    logic signed [12:0] diag;
    logic signed [12:0] acc;
    for (int k = 0; k < 9; k++) p[k] = $signed({5'b0, n[8*k +: 8]});
    orth = p[1] + p[3] + p[5] + p[7];
    diag = p[0] + p[2] + p[6] + p[8];
    case (op_t'(op))
      OP_BLUR:  acc = ((p[4] <<< 2) + (orth <<< 1) + diag) >>> 4;
      OP_SHARP: acc = (p[4] <<< 2) + p[4] - orth;
`ifdef IMG_EDGE_EN
      OP_EDGE:  acc = (p[4] <<< 3) - orth - diag;
`endif
      default:  acc = p[4];
    endcase
    return clamp8(acc);
  endfunction

  // Split the neighbourhood per channel and run the kernel on each channel.
  always_comb begin
    w_chan = '{default: '0};
    o_pix  = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 9; k++) w_chan[ch][8*k +: 8] = i_win[PIX_W*k + 8*ch +: 8];
      o_pix[8*ch +: 8] = calcChan(i_op, w_chan[ch]);
    end
  end

endmodule

// File: rtl/img_conv_engine.sv
// img_conv_engine: row-sequenced 3x3 filter engine. Reads rows of the chosen
// source image through the buffer's three read ports, keeps a sliding
// top/mid/bottom window, filters all 128 pixels of a row in parallel and
// writes each filtered row into the recent image. Four cycles per row.
// Optional feature macro: IMG_EDGE_EN (accepts op 3 as the Laplacian; when
// undefined op 3 raises err and completes immediately without bus activity).
module img_conv_engine
  import img_coproc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_src_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [6:0]       o_raddr0,
  output logic [6:0]       o_raddr1,
  output logic [6:0]       o_raddr2,
  output logic             o_re,
  output logic             o_img_idx,
  input  logic [ROW_W-1:0] i_rdata0,
  input  logic [ROW_W-1:0] i_rdata1,
  input  logic [ROW_W-1:0] i_rdata2,
  output logic [8:0]       o_waddr,
  output logic             o_we,
  output logic [ROW_W-1:0] o_wdata
);

  conv_state_t      r_state;
  logic [1:0]       r_op;
  logic             r_src;
  logic [6:0]       r_row;
  logic [ROW_W-1:0] r_top;
  logic [ROW_W-1:0] r_mid;
  logic [ROW_W-1:0] r_bot;
  logic [ROW_W-1:0] w_res;
  logic [6:0]       w_nextRd;
  logic             w_opLegal;

`ifdef IMG_EDGE_EN
  assign w_opLegal = 1'b1;
`else
  assign w_opLegal = (op_t'(i_op) != OP_EDGE);
`endif

  // The row after next is the new bottom tap; clamp so row 128 replicates row 127.
  assign w_nextRd  = (r_row >= 7'(IMG_H - 2)) ? 7'(IMG_H - 1) : r_row + 7'd2;
  assign o_img_idx = r_src;

  // Sequencer: all bus controls and status flags are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_src    <= 1'b0;
      r_row    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_re     <= 1'b0;
      o_we     <= 1'b0;
      o_raddr0 <= '0;
      o_raddr1 <= '0;
      o_raddr2 <= '0;
      o_waddr  <= '0;
      o_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op  <= i_op;
            r_src <= i_src_sel;
            r_row <= '0;
            if (w_opLegal) begin
              o_err    <= 1'b0;
              o_busy   <= 1'b1;
              o_re     <= 1'b1;
              o_raddr0 <= '0;
              o_raddr1 <= '0;
              o_raddr2 <= 7'd1;
              r_state  <= S_RD;
            end else begin
              o_err   <= 1'b1;
              o_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_RD: begin
          o_re    <= 1'b0;
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_state <= S_CALC;
        end
        S_CALC: begin
          o_wdata <= w_res;
          o_we    <= 1'b1;
          o_waddr <= {2'b00, r_row};
          r_state <= S_WR;
        end
        S_WR: begin
          o_we <= 1'b0;
          if (r_row == 7'(IMG_H - 1)) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_row    <= r_row + 7'd1;
            o_raddr2 <= w_nextRd;
            o_re     <= 1'b1;
            r_state  <= S_RD;
          end
        end
        S_FIN: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slide the row window; the first row loads all three taps (row -1 reads as row 0).
  always_ff @(posedge i_clk) begin
    if (r_state == S_CAP) begin
      if (r_row == 7'd0) begin
        r_top <= i_rdata0;
        r_mid <= i_rdata1;
        r_bot <= i_rdata2;
      end else begin
        r_top <= r_mid;
        r_mid <= r_bot;
        r_bot <= i_rdata2;
      end
    end
  end

  for (genvar p = 0; p < IMG_W; p++) begin : g_px
    localparam int PL = (p == 0) ? 0 : p - 1;
    localparam int PR = (p == IMG_W - 1) ? IMG_W - 1 : p + 1;
    logic [9*PIX_W-1:0] w_win;

    assign w_win = {r_bot[PIX_W*PR +: PIX_W], r_bot[PIX_W*p +: PIX_W], r_bot[PIX_W*PL +: PIX_W],
                    r_mid[PIX_W*PR +: PIX_W], r_mid[PIX_W*p +: PIX_W], r_mid[PIX_W*PL +: PIX_W],
                    r_top[PIX_W*PR +: PIX_W], r_top[PIX_W*p +: PIX_W], r_top[PIX_W*PL +: PIX_W]};

    img_kernel_px u_px (
      .i_win (w_win),
      .i_op  (r_op),
      .o_pix (w_res[PIX_W*p +: PIX_W])
    );
  end

endmodule

// File: tb/tb_img_conv_engine.sv
// tb_img_conv_engine: table of filter runs against a dual-image row buffer
// model, with a row scoreboard fed from an independent reference filter,
// plus hand-written reset-recovery and single-pixel sequences.
module tb_img_conv_engine;
  import img_coproc_pkg::*;

`ifdef IMG_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  localparam int PAT_KEEP   = 0;
  localparam int PAT_UNI    = 1;
  localparam int PAT_SINGLE = 2;
  localparam int PAT_RAND   = 3;

  localparam int HC_NONE  = 0;
  localparam int HC_BLUR  = 1;
  localparam int HC_SHARP = 2;
  localparam int HC_SAVE  = 3;
  localparam int HC_SAME  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic             srcSel;
  logic             busy, done, err, re, we, imgIdx;
  logic [6:0]       raddr0, raddr1, raddr2;
  logic [8:0]       waddr;
  logic [ROW_W-1:0] rdata0, rdata1, rdata2, wdata;

  logic [ROW_W-1:0] memOrig   [IMG_H];
  logic [ROW_W-1:0] memRecent [IMG_H];
  logic [ROW_W-1:0] srcSnap   [IMG_H];
  logic [ROW_W-1:0] savedImg  [IMG_H];

  typedef struct {
    logic [6:0]       row;
    logic [ROW_W-1:0] data;
  } exp_t;
  exp_t expQ [$];

  typedef struct {
    logic [1:0] op;
    logic       src;
    int         pattern;
    int         injectAt;
    int         handCheck;
    logic       expErr;
    int         expDone;
    int         expWrites;
  } run_vec_t;
  run_vec_t tbl [10];

  int checkCount = 0;
  int failCount  = 0;
  int runCyc;
  int runWrites;

  img_conv_engine dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_op      (op),
    .i_src_sel (srcSel),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .o_raddr0  (raddr0),
    .o_raddr1  (raddr1),
    .o_raddr2  (raddr2),
    .o_re      (re),
    .o_img_idx (imgIdx),
    .i_rdata0  (rdata0),
    .i_rdata1  (rdata1),
    .i_rdata2  (rdata2),
    .o_waddr   (waddr),
    .o_we      (we),
    .o_wdata   (wdata)
  );

  always #5 clk = ~clk;

  // Row buffer read side: registered read, data appears the cycle after re.
  always @(posedge clk) begin
    if (re) begin
      rdata0 <= imgIdx ? memRecent[raddr0] : memOrig[raddr0];
      rdata1 <= imgIdx ? memRecent[raddr1] : memOrig[raddr1];
      rdata2 <= imgIdx ? memRecent[raddr2] : memOrig[raddr2];
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkRow(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    int bad;
    bad = 0;
    for (int p = 0; p < IMG_W; p++) begin
      if (act[PIX_W*p +: PIX_W] != exp[PIX_W*p +: PIX_W]) begin
        bad = p;
        break;
      end
    end
    checkOutput($sformatf("%s px%0d", name, bad),
                longint'(act[PIX_W*bad +: PIX_W]), longint'(exp[PIX_W*bad +: PIX_W]));
  endtask

  function automatic int pixCh(int r, int c, int ch);
    int rr;
    int cc;
    rr = (r < 0) ? 0 : ((r > IMG_H - 1) ? IMG_H - 1 : r);
    cc = (c < 0) ? 0 : ((c > IMG_W - 1) ? IMG_W - 1 : c);
    return int'(srcSnap[rr][PIX_W*cc + 8*ch +: 8]);
  endfunction

  function automatic logic [7:0] refChan(int r, int c, int ch, logic [1:0] o);
    int ctr, orth, diag, v;
    ctr  = pixCh(r, c, ch);
    orth = pixCh(r-1, c, ch) + pixCh(r+1, c, ch) + pixCh(r, c-1, ch) + pixCh(r, c+1, ch);
    diag = pixCh(r-1, c-1, ch) + pixCh(r-1, c+1, ch) + pixCh(r+1, c-1, ch) + pixCh(r+1, c+1, ch);
    case (o)
      2'd0:    v = ctr;
      2'd1:    v = (4*ctr + 2*orth + diag) / 16;
      2'd2:    v = 5*ctr - orth;
      default: v = 8*ctr - orth - diag;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  function automatic int gChan(int r, int p);
    return int'(memRecent[r][PIX_W*p + 8 +: 8]);
  endfunction

  // Advance to the next falling edge; any write seen there is scored and stored.
  task automatic stepCycle();
    exp_t e;
    @(negedge clk);
    runCyc++;
    if (we) begin
      if (expQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpected write actual_waddr=%0d required=no_write", waddr);
      end else begin
        e = expQ.pop_front();
        checkOutput("waddr", longint'(waddr), longint'({2'b00, e.row}));
        checkRow($sformatf("wdata r%0d", e.row), wdata, e.data);
      end
      checkOutput("write cycle", runCyc, 4*runWrites + 4);
      runWrites++;
      memRecent[waddr[6:0]] = wdata;
    end
  endtask

  task automatic loadImage(input logic s, input int pat);
    logic [ROW_W-1:0] row;
    if (pat == PAT_KEEP) return;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (pat)
          PAT_UNI:    row[PIX_W*c +: PIX_W] = 24'h404040;
          PAT_SINGLE: row[PIX_W*c +: PIX_W] = 24'h000000;
          default:    row[PIX_W*c +: PIX_W] = 24'($urandom);
        endcase
      end
      if (pat == PAT_SINGLE && r == 64) row[PIX_W*64 + 8 +: 8] = 8'hFF;
      if (s) memRecent[r] = row;
      else memOrig[r] = row;
    end
  endtask

  // Push the expected rows, pulse start, then run until done, a reset point or the budget.
  task automatic applyStimulus(input logic [1:0] o, input logic s, input int injectAt, input int rstAt,
                               output int doneCyc, output int reads, output logic errAtDone);
    bit   legal;
    exp_t e;
    legal = (o != 2'd3) || EDGE_EN;
    for (int r = 0; r < IMG_H; r++) srcSnap[r] = s ? memRecent[r] : memOrig[r];
    if (legal) begin
      for (int r = 0; r < IMG_H; r++) begin
        e.row = 7'(r);
        for (int c = 0; c < IMG_W; c++)
          for (int ch = 0; ch < 3; ch++) e.data[PIX_W*c + 8*ch +: 8] = refChan(r, c, ch, o);
        expQ.push_back(e);
      end
    end
    op = o;
    srcSel = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    runCyc = 0;
    runWrites = 0;
    doneCyc = -1;
    reads = 0;
    errAtDone = 1'b0;
    while (doneCyc < 0 && runCyc < 700) begin
      stepCycle();
      if (re) reads++;
      if (runCyc == 1) begin
        checkOutput("img_idx cycle1", longint'(imgIdx), longint'(s));
        checkOutput("busy cycle1", longint'(busy), longint'(legal));
        checkOutput("re cycle1", longint'(re), longint'(legal));
        if (legal) begin
          checkOutput("raddr0 row0", longint'(raddr0), 0);
          checkOutput("raddr1 row0", longint'(raddr1), 0);
          checkOutput("raddr2 row0", longint'(raddr2), 1);
        end
      end
      if (legal && runCyc == 5) checkOutput("raddr2 row1", longint'(raddr2), 2);
      if (legal && runCyc == 509) checkOutput("raddr2 row127 clamp", longint'(raddr2), 127);
      if (runCyc == injectAt) begin
        start = 1'b1;
        op = 2'd1;
      end
      if (runCyc == injectAt + 1) begin
        start = 1'b0;
        op = o;
      end
      if (runCyc == rstAt) rst = 1'b1;
      if (rstAt > 0 && runCyc == rstAt + 1) begin
        checkOutput("re after reset", longint'(re), 0);
        checkOutput("we after reset", longint'(we), 0);
        checkOutput("busy after reset", longint'(busy), 0);
        checkOutput("done after reset", longint'(done), 0);
        rst = 1'b0;
        break;
      end
      if (done) begin
        doneCyc = runCyc;
        errAtDone = err;
        checkOutput("busy at done", longint'(busy), 0);
      end
    end
  endtask

  initial begin
    int   doneCyc;
    int   reads;
    int   diffs;
    logic errAtDone;

    rst = 1'b1;
    start = 1'b0;
    op = 2'd0;
    srcSel = 1'b0;
    for (int r = 0; r < IMG_H; r++) begin
      memOrig[r] = '0;
      memRecent[r] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset err", longint'(err), 0);
    checkOutput("reset re", longint'(re), 0);
    checkOutput("reset we", longint'(we), 0);
    checkOutput("reset img_idx", longint'(imgIdx), 0);
    checkOutput("reset raddr2", longint'(raddr2), 0);
    checkOutput("reset waddr", longint'(waddr), 0);
    checkOutput("reset wdata zero", longint'(wdata == '0), 1);
    rst = 1'b0;

    tbl[0] = '{2'd1, 1'b0, PAT_UNI,    -1,  HC_NONE,  1'b0, 513, 128};
    tbl[1] = '{2'd1, 1'b0, PAT_SINGLE, -1,  HC_BLUR,  1'b0, 513, 128};
    tbl[2] = '{2'd2, 1'b0, PAT_SINGLE, -1,  HC_SHARP, 1'b0, 513, 128};
    tbl[3] = '{2'd0, 1'b1, PAT_RAND,   -1,  HC_SAVE,  1'b0, 513, 128};
    tbl[4] = '{2'd0, 1'b1, PAT_KEEP,   100, HC_SAME,  1'b0, 513, 128};
    tbl[5] = '{2'd3, 1'b0, PAT_UNI,    -1,  HC_NONE,  !EDGE_EN, EDGE_EN ? 513 : 1, EDGE_EN ? 128 : 0};
    tbl[6] = '{2'd1, 1'b0, PAT_RAND,   -1,  HC_NONE,  1'b0, 513, 128};
    tbl[7] = '{2'd2, 1'b0, PAT_RAND,   -1,  HC_NONE,  1'b0, 513, 128};
    tbl[8] = '{2'd3, 1'b0, PAT_RAND,   -1,  HC_NONE,  !EDGE_EN, EDGE_EN ? 513 : 1, EDGE_EN ? 128 : 0};
    tbl[9] = '{2'd0, 1'b0, PAT_KEEP,   -1,  HC_NONE,  1'b0, 513, 128};

    for (int i = 0; i < 10; i++) begin
      loadImage(tbl[i].src, tbl[i].pattern);
      if (tbl[i].handCheck == HC_SAVE)
        for (int r = 0; r < IMG_H; r++) savedImg[r] = memRecent[r];
      applyStimulus(tbl[i].op, tbl[i].src, tbl[i].injectAt, -1, doneCyc, reads, errAtDone);
      checkOutput($sformatf("run%0d done cycle", i), doneCyc, tbl[i].expDone);
      checkOutput($sformatf("run%0d writes", i), runWrites, tbl[i].expWrites);
      checkOutput($sformatf("run%0d read cycles", i), reads, tbl[i].expWrites);
      checkOutput($sformatf("run%0d err", i), longint'(errAtDone), longint'(tbl[i].expErr));
      checkOutput($sformatf("run%0d rows pending", i), expQ.size(), 0);
      expQ.delete();
      stepCycle();
      checkOutput($sformatf("run%0d done one cycle", i), longint'(done), 0);
      checkOutput($sformatf("run%0d err sticky", i), longint'(err), longint'(tbl[i].expErr));
      if (tbl[i].handCheck == HC_BLUR) begin
        checkOutput("blur centre G", gChan(64, 64), 8'h3F);
        checkOutput("blur west G", gChan(64, 63), 8'h1F);
        checkOutput("blur east G", gChan(64, 65), 8'h1F);
        checkOutput("blur north G", gChan(63, 64), 8'h1F);
        checkOutput("blur south G", gChan(65, 64), 8'h1F);
        checkOutput("blur diag nw G", gChan(63, 63), 8'h0F);
        checkOutput("blur diag se G", gChan(65, 65), 8'h0F);
        checkOutput("blur far G", gChan(64, 62), 0);
      end
      if (tbl[i].handCheck == HC_SHARP) begin
        checkOutput("sharp centre G", gChan(64, 64), 8'hFF);
        checkOutput("sharp west G", gChan(64, 63), 0);
        checkOutput("sharp north G", gChan(63, 64), 0);
        checkOutput("sharp centre R", longint'(memRecent[64][PIX_W*64 + 16 +: 8]), 0);
      end
      if (tbl[i].handCheck == HC_SAME) begin
        diffs = 0;
        for (int r = 0; r < IMG_H; r++) if (memRecent[r] != savedImg[r]) diffs++;
        checkOutput("copy twice rows changed", diffs, 0);
      end
    end

    // Reset during the write of row 10, then a fresh full run.
    loadImage(1'b0, PAT_RAND);
    applyStimulus(2'd0, 1'b0, -1, 44, doneCyc, reads, errAtDone);
    checkOutput("rows left after reset", expQ.size(), 117);
    checkOutput("writes before reset", runWrites, 11);
    expQ.delete();
    applyStimulus(2'd0, 1'b0, -1, -1, doneCyc, reads, errAtDone);
    checkOutput("post-reset done cycle", doneCyc, 513);
    checkOutput("post-reset writes", runWrites, 128);
    checkOutput("post-reset rows pending", expQ.size(), 0);
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
